// File: rtl/counter_share_ctrl_pkg.sv
// Types and helpers for the shared-counter controller.
// Elapsed count is taken modulo the counter width by the caller.
package counter_ctrl_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int ELAPSED_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [ELAPSED_W-1:0] elapsed(
        input logic [ELAPSED_W-1:0] q,
        input logic [ELAPSED_W-1:0] base
    );
        return q - base;
    endfunction

endpackage

// File: rtl/counter_share_ctrl_if.sv
// Bundle between the requesters/shared counter (master) and the controller (slave).
interface counter_share_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = CNT_W_DEF
);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] len;
    logic [CNT_W-1:0]         q_in;
    logic                     count_en;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    modport master (
        output req, len, q_in,
        input  count_en, grant, done, busy
    );

    modport slave (
        input  req, len, q_in,
        output count_en, grant, done, busy
    );

endinterface

// File: rtl/counter_share_ctrl_rr_arbiter.sv
// Combinational round-robin select: first set request at or after last_idx+1.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_idx_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        int cand;
        cand    = 0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_idx_i) + k) % NUM_REQ;
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/counter_share_ctrl.sv
// Time-shares one free-running counter among requesters; each owner gets a run
// of len increments measured from a base latched at grant.
//
//   state | meaning
//   IDLE  | no owner; arbitrate pending requests
//   RUN   | owner granted, counter enabled until elapsed == target
//   DONE  | one-cycle completion pulse to the owner
module counter_share_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    counter_share_ctrl_if.slave bus_if
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [ELAPSED_W-1:0] CNT_MASK = ELAPSED_W'((1 << CNT_W) - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   base_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [CNT_W-1:0]   len_sel;
    logic [NUM_REQ-1:0] arb_onehot;
    logic               reached;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i      (bus_if.req),
        .last_idx_i (last_idx_q),
        .valid_o    (arb_valid),
        .idx_o      (arb_idx)
    );

    assign len_sel    = bus_if.len[int'(arb_idx)*CNT_W +: CNT_W];
    assign arb_onehot = NUM_REQ'(1) << arb_idx;

    // Wrap-safe: compare the modular distance from base, not absolute values.
    assign reached = (elapsed(ELAPSED_W'(bus_if.q_in), ELAPSED_W'(base_q)) & CNT_MASK)
                     == ELAPSED_W'(tgt_q);

    assign bus_if.count_en = (state_q == RUN) && !reached;
    assign bus_if.grant    = grant_q;
    assign bus_if.done     = done_q;
    assign bus_if.busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
            tgt_q      <= '0;
            base_q     <= '0;
            grant_q    <= '0;
            done_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (arb_valid) begin
                        idx_q   <= arb_idx;
                        tgt_q   <= len_sel;
                        base_q  <= bus_if.q_in;
                        grant_q <= arb_onehot;
                        if (len_sel == '0) begin
                            state_q <= DONE;
                            done_q  <= arb_onehot;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Completion takes precedence over a same-cycle request drop.
                    if (reached) begin
                        state_q <= DONE;
                        done_q  <= grant_q;
                    end else if (!bus_if.req[idx_q]) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        last_idx_q <= idx_q;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= '0;
                    grant_q    <= '0;
                    last_idx_q <= idx_q;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Scoreboard bench for counter_share_ctrl with a behavioural 4-bit counter and
// a round-robin reference model.
module tb_counter_share_ctrl;
    import counter_ctrl_pkg::*;

    localparam int N = 4;
    localparam int W = 4;
    localparam int MOD = 1 << W;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    counter_share_ctrl_if #(.NUM_REQ(N), .CNT_W(W)) bus ();

    counter_share_ctrl #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_if  (bus)
    );

    // shared counter: never cleared, optional preload while controller is idle
    logic [W-1:0] cnt_q = '0;
    logic         load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    always @(posedge clk) begin
        if (load_en) cnt_q <= load_val;
        else if (bus.count_en) cnt_q <= cnt_q + 1'b1;
    end
    assign bus.q_in = cnt_q;

    typedef struct {
        int owner;
        bit got_done;
        int n_grant;
        int n_en;
        int q_end;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   m_last = N - 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int rr_pick(input int rem[N], input int last);
        for (int k = 1; k <= N; k++) begin
            int c = (last + k) % N;
            if (rem[c] > 0) return c;
        end
        return -1;
    endfunction

    task automatic push_run(input int owner, input int l, inout int q);
        exp_t e;
        e.owner    = owner;
        e.got_done = 1'b1;
        e.n_grant  = (l == 0) ? 1 : l + 2;
        e.n_en     = l;
        q          = (q + l) % MOD;
        e.q_end    = q;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic [N-1:0] own_g = '0;
    bit   active = 1'b0;
    bit   seen_done = 1'b0;
    int   ng = 0, ne = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            active = 1'b0;
        end else begin
            if (active && bus.grant != own_g) begin
                if (sb.size() == 0) begin
                    check("unexpected_episode", int'(own_g), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("owner", int'(own_g), 1 << mon_e.owner);
                    check("done_seen", int'(seen_done), int'(mon_e.got_done));
                    check("grant_cycles", ng, mon_e.n_grant);
                    check("count_en_cycles", ne, mon_e.n_en);
                    check("q_end", int'(cnt_q), mon_e.q_end);
                end
                active = 1'b0;
            end
            if (!active && bus.grant != '0) begin
                active    = 1'b1;
                own_g     = bus.grant;
                ng        = 0;
                ne        = 0;
                seen_done = 1'b0;
            end
            if (active) begin
                ng++;
                if (bus.count_en) ne++;
                if (bus.done != '0) begin
                    seen_done = 1'b1;
                    check("done_onehot", int'(bus.done), int'(own_g));
                end
            end else begin
                check("count_en_idle", int'(bus.count_en), 0);
                check("done_idle", int'(bus.done), 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        m_last = N - 1;
        @(negedge clk);
    endtask

    task automatic preload(input logic [W-1:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", int'(ok), 1);
    endtask

    // Each requester asks rounds[i] times in a row (holding req through done).
    task automatic serve(input int rounds[N], input int lens[N]);
        int rem[N];
        int q;
        int p;
        int budget;
        bit all_zero;
        rem = rounds;
        q   = int'(cnt_q);
        p   = rr_pick(rem, m_last);
        while (p >= 0) begin
            push_run(p, lens[p], q);
            rem[p]--;
            m_last = p;
            p = rr_pick(rem, m_last);
        end
        rem    = rounds;
        budget = 20;
        for (int i = 0; i < N; i++) begin
            budget += rounds[i] * (lens[i] + 4);
            bus.len[i*W +: W] = W'(lens[i]);
            bus.req[i] = (rounds[i] > 0);
        end
        all_zero = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            all_zero = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (bus.done[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) bus.req[i] = 1'b0;
                end
                if (rem[i] != 0) all_zero = 1'b0;
            end
            if (all_zero && !bus.busy) break;
        end
        check("serve_complete", int'(all_zero && !bus.busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int rounds[N];
        int lens[N];
        int q;
        int k;
        exp_t e;

        bus.req = '0;
        bus.len = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_count_en", int'(bus.count_en), 0);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        // single requester from counter value 0
        preload(4'd0);
        serve('{1, 0, 0, 0}, '{3, 0, 0, 0});

        // fairness: 0 then 2, 0 holds through done so 2 goes before 0 again
        do_reset();
        serve('{2, 0, 1, 0}, '{2, 0, 2, 0});

        // wrap from 14 with len 5
        preload(4'd14);
        serve('{1, 0, 0, 0}, '{5, 0, 0, 0});

        // zero-length request
        serve('{0, 0, 0, 1}, '{0, 0, 0, 0});

        // abandon after two increments, pending req1 takes over from current q
        do_reset();
        q = int'(cnt_q);
        e.owner = 0; e.got_done = 1'b0; e.n_grant = 2; e.n_en = 2;
        q = (q + 2) % MOD; e.q_end = q;
        sb.push_back(e);
        push_run(1, 3, q);
        m_last = 1;
        bus.len = '0;
        bus.len[0*W +: W] = 4'd8;
        bus.len[1*W +: W] = 4'd3;
        bus.req = 4'b0011;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.count_en) k++;
            if (k == 2) begin
                bus.req[0] = 1'b0;
                break;
            end
        end
        check("abandon_reached", k, 2);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done[1]) begin
                bus.req[1] = 1'b0;
                break;
            end
        end
        wait_idle(10);

        // asynchronous reset in the middle of a run
        bus.len = '0;
        bus.len[0*W +: W] = 4'd8;
        bus.req = 4'b0001;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_count_en", int'(bus.count_en), 0);
        check("midrst_grant", int'(bus.grant), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        m_last = N - 1;
        @(negedge clk);
        serve('{1, 1, 0, 0}, '{2, 3, 0, 0});

        // randomized batches
        for (int b = 0; b < 8; b++) begin
            bit any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                rounds[i] = int'($urandom_range(0, 2));
                lens[i]   = int'($urandom_range(0, 15));
                if (rounds[i] != 0) any = 1'b1;
            end
            if (!any) rounds[$urandom_range(0, N-1)] = 1;
            if ($urandom_range(0, 2) == 0) preload(W'($urandom_range(0, MOD-1)));
            serve(rounds, lens);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
